// File: rtl/execute_stage_gen.sv
// Execute stage: N-way operand forwarding, single-cycle ALU, registered result with valid/ready,
// flag register with one-deep shadow. Define EXEC_MUL_EN to build the iterative shift-add multiplier.
module execute_stage_gen #(
  parameter int unsigned DW     = 16,
  parameter int unsigned FWD_CH = 2,
  parameter int unsigned AW     = 3
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [AW-1:0]        src_addr,
  input  logic [AW-1:0]        dst_addr,
  input  logic [DW-1:0]        src_val,
  input  logic [DW-1:0]        dst_val,
  input  logic [DW-1:0]        imm,
  input  logic                 use_imm,
  input  logic                 flags_we,
  input  logic                 flags_save,
  input  logic                 flags_restore,
  input  logic                 wb_in,
  input  logic [FWD_CH-1:0]    fwd_wb,
  input  logic [FWD_CH*AW-1:0] fwd_addr,
  input  logic [FWD_CH*DW-1:0] fwd_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_result,
  output logic [DW-1:0]        out_result_hi,
  output logic [AW-1:0]        out_dst_addr,
  output logic                 out_wb,
  output logic [2:0]           flags,
  output logic                 busy
);

  localparam logic [2:0] OP_PASS_B = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_AND    = 3'd3;
  localparam logic [2:0] OP_OR     = 3'd4;
  localparam logic [2:0] OP_NOT_A  = 3'd5;
  localparam logic [2:0] OP_MUL    = 3'd6;
  localparam logic [2:0] OP_INC_B  = 3'd7;

  logic [DW-1:0] w_op_a, w_rdst, w_op_b, w_res;
  logic [DW:0]   w_wide;
  logic          w_c, w_slot_free, w_idle, w_accept, w_alu_load, w_mul_load;
  logic          w_fl_we, w_mul_wb, w_mul_fwe;
  logic [2:0]    w_alu_flags, w_mul_flags, w_fl_val;
  logic [DW-1:0] w_mul_lo, w_mul_hi;
  logic [AW-1:0] w_mul_dst;

  logic          r_out_valid, r_out_wb;
  logic [DW-1:0] r_out_result, r_out_hi;
  logic [AW-1:0] r_out_dst;
  logic [2:0]    r_flags, r_shadow;

  // Walk sources oldest to youngest so the lowest matching index overrides last
  always_comb begin
    w_op_a = src_val;
    w_rdst = dst_val;
    for (int k = int'(FWD_CH) - 1; k >= 0; k--) begin
      if (fwd_wb[k] && (fwd_addr[k*AW +: AW] == src_addr)) w_op_a = fwd_val[k*DW +: DW];
      if (fwd_wb[k] && (fwd_addr[k*AW +: AW] == dst_addr)) w_rdst = fwd_val[k*DW +: DW];
    end
  end

  assign w_op_b      = use_imm ? imm : w_rdst;
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = w_idle && w_slot_free;
  assign w_accept    = in_valid && in_ready;

  // Single-cycle ALU; logic ops carry the current C through
  always_comb begin
    w_res  = '0;
    w_c    = r_flags[0];
    w_wide = '0;
    case (op)
      OP_PASS_B: w_res = w_op_b;
      OP_ADD: begin
        w_wide = {1'b0, w_op_a} + {1'b0, w_op_b};
        w_res  = w_wide[DW-1:0];
        w_c    = w_wide[DW];
      end
      OP_SUB: begin
        w_res = w_op_a - w_op_b;
        w_c   = (w_op_a < w_op_b);
      end
      OP_AND:   w_res = w_op_a & w_op_b;
      OP_OR:    w_res = w_op_a | w_op_b;
      OP_NOT_A: w_res = ~w_op_a;
      OP_INC_B: begin
        w_wide = {1'b0, w_op_b} + (DW+1)'(1);
        w_res  = w_wide[DW-1:0];
        w_c    = w_wide[DW];
      end
      default:  w_res = '0;
    endcase
  end

  assign w_alu_flags = {(w_res == '0), w_res[DW-1], w_c};

`ifdef EXEC_MUL_EN
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t          r_state;
  logic [2*DW-1:0] r_acc;
  logic [DW-1:0]   r_mcand;
  logic [CW-1:0]   r_cnt;
  logic            r_busy, r_mul_fwe, r_mul_wb;
  logic [AW-1:0]   r_mul_dst;
  logic [DW:0]     w_step;

  // r_acc = {partial high, remaining multiplier bits}; one multiplier bit retired per cycle
  assign w_step = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_mul_fwe <= 1'b0;
      r_mul_wb  <= 1'b0;
      r_mul_dst <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept && (op == OP_MUL)) begin
          r_state   <= S_MUL;
          r_acc     <= {DW'(0), w_op_b};
          r_mcand   <= w_op_a;
          r_cnt     <= '0;
          r_busy    <= 1'b1;
          r_mul_fwe <= flags_we;
          r_mul_wb  <= wb_in;
          r_mul_dst <= dst_addr;
        end
        S_MUL: begin
          r_acc <= {w_step, r_acc[DW-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(DW - 1)) r_state <= S_DONE;
        end
        S_DONE: if (w_slot_free) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_idle     = (r_state == S_IDLE);
  assign w_mul_load = (r_state == S_DONE) && w_slot_free;
  assign w_alu_load = w_accept && (op != OP_MUL);
  assign w_mul_lo   = r_acc[DW-1:0];
  assign w_mul_hi   = r_acc[2*DW-1:DW];
  assign w_mul_dst  = r_mul_dst;
  assign w_mul_wb   = r_mul_wb;
  assign w_mul_fwe  = r_mul_fwe;
  assign busy       = r_busy;
`else
  assign w_idle     = 1'b1;
  assign w_mul_load = 1'b0;
  assign w_alu_load = w_accept;
  assign w_mul_lo   = '0;
  assign w_mul_hi   = '0;
  assign w_mul_dst  = '0;
  assign w_mul_wb   = 1'b0;
  assign w_mul_fwe  = 1'b0;
  assign busy       = 1'b0;
`endif

  assign w_mul_flags = {({w_mul_hi, w_mul_lo} == '0), w_mul_hi[DW-1], (w_mul_hi != '0)};
  assign w_fl_we     = (w_alu_load && flags_we && (op != OP_MUL)) || (w_mul_load && w_mul_fwe);
  assign w_fl_val    = w_mul_load ? w_mul_flags : w_alu_flags;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_hi     <= '0;
      r_out_dst    <= '0;
      r_out_wb     <= 1'b0;
    end else if (w_alu_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_res;
      r_out_hi     <= '0;
      r_out_dst    <= dst_addr;
      r_out_wb     <= wb_in;
    end else if (w_mul_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_mul_lo;
      r_out_hi     <= w_mul_hi;
      r_out_dst    <= w_mul_dst;
      r_out_wb     <= w_mul_wb;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Restore beats a same-cycle op write; save+restore swaps through the nonblocking pair
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_flags  <= '0;
      r_shadow <= '0;
    end else begin
      if (in_ready && flags_restore) r_flags <= r_shadow;
      else if (w_fl_we)              r_flags <= w_fl_val;
      if (in_ready && flags_save)    r_shadow <= r_flags;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_result    = r_out_result;
  assign out_result_hi = r_out_hi;
  assign out_dst_addr  = r_out_dst;
  assign out_wb        = r_out_wb;
  assign flags         = r_flags;

endmodule

// File: tb/tb_execute_stage_gen.sv
// Directed bench for execute_stage_gen; covers the multiplier path when EXEC_MUL_EN is defined.
module tb_execute_stage_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned FWD_CH = 2;
  localparam int unsigned AW = 3;

  localparam logic [2:0] OP_PASS_B = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_AND    = 3'd3;
  localparam logic [2:0] OP_OR     = 3'd4;
  localparam logic [2:0] OP_NOT_A  = 3'd5;
  localparam logic [2:0] OP_MUL    = 3'd6;
  localparam logic [2:0] OP_INC_B  = 3'd7;

  logic                 CLK = 1'b0;
  logic                 Reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [2:0]           op = '0;
  logic [AW-1:0]        src_addr = '0;
  logic [AW-1:0]        dst_addr = '0;
  logic [DW-1:0]        src_val = '0;
  logic [DW-1:0]        dst_val = '0;
  logic [DW-1:0]        imm = '0;
  logic                 use_imm = 1'b1;
  logic                 flags_we = 1'b0;
  logic                 flags_save = 1'b0;
  logic                 flags_restore = 1'b0;
  logic                 wb_in = 1'b0;
  logic [FWD_CH-1:0]    fwd_wb = '0;
  logic [FWD_CH*AW-1:0] fwd_addr = '0;
  logic [FWD_CH*DW-1:0] fwd_val = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DW-1:0]        out_result;
  logic [DW-1:0]        out_result_hi;
  logic [AW-1:0]        out_dst_addr;
  logic                 out_wb;
  logic [2:0]           flags;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage_gen #(.DW(DW), .FWD_CH(FWD_CH), .AW(AW)) dut (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_addr(src_addr), .dst_addr(dst_addr), .src_val(src_val), .dst_val(dst_val),
    .imm(imm), .use_imm(use_imm), .flags_we(flags_we), .flags_save(flags_save),
    .flags_restore(flags_restore), .wb_in(wb_in), .fwd_wb(fwd_wb), .fwd_addr(fwd_addr),
    .fwd_val(fwd_val), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_result_hi(out_result_hi), .out_dst_addr(out_dst_addr), .out_wb(out_wb),
    .flags(flags), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one instruction for a single cycle; b drives both imm and dst_val
  task automatic issue(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic fwe, input logic ui);
    op = o; src_val = a; dst_val = b; imm = b; flags_we = fwe; use_imm = ui; in_valid = 1'b1;
    #1;
    check_eq("accept_ready", 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    flags_we = 1'b0;
  endtask

  initial begin
    int stall;
    int seen;
    // Reset state
    tick();
    tick();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", 32'(out_result), 32'd0);
    check_eq("rst_flags", 32'(flags), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    Reset = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD overflow to zero
    wb_in = 1'b1; dst_addr = 3'd5;
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 1'b1);
    check_eq("add_valid", 32'(out_valid), 32'd1);
    check_eq("add_result", 32'(out_result), 32'h0000);
    check_eq("add_hi", 32'(out_result_hi), 32'h0000);
    check_eq("add_flags", 32'(flags), 32'b101);
    check_eq("add_dst", 32'(out_dst_addr), 32'd5);
    check_eq("add_wb", 32'(out_wb), 32'd1);
    wb_in = 1'b0;

    // Forwarding priority and fallback
    src_addr = 3'd3; dst_addr = 3'd3;
    fwd_wb = 2'b11; fwd_addr = {3'd3, 3'd3}; fwd_val = {16'h2222, 16'h1111};
    issue(OP_PASS_B, 16'h0000, 16'h5555, 1'b0, 1'b0);
    check_eq("fwd_both", 32'(out_result), 32'h1111);
    check_eq("fwd_dst", 32'(out_dst_addr), 32'd3);
    fwd_wb = 2'b10;
    issue(OP_PASS_B, 16'h0000, 16'h5555, 1'b0, 1'b0);
    check_eq("fwd_src1", 32'(out_result), 32'h2222);
    fwd_wb = 2'b11; dst_addr = 3'd6;
    issue(OP_ADD, 16'h0AAA, 16'h0001, 1'b0, 1'b1);
    check_eq("fwd_opa", 32'(out_result), 32'h1112);
    fwd_addr = {3'd4, 3'd4}; dst_addr = 3'd3;
    issue(OP_PASS_B, 16'h0000, 16'h5555, 1'b0, 1'b0);
    check_eq("fwd_nomatch", 32'(out_result), 32'h5555);
    check_eq("fwd_flags_hold", 32'(flags), 32'b101);
    fwd_wb = '0; src_addr = '0; dst_addr = '0;

    // ALU ops and flag behaviour
    issue(OP_SUB, 16'h0007, 16'h0009, 1'b1, 1'b1);
    check_eq("sub_result", 32'(out_result), 32'hFFFE);
    check_eq("sub_flags", 32'(flags), 32'b011);
    issue(OP_AND, 16'hF0F0, 16'h0FF0, 1'b1, 1'b1);
    check_eq("and_result", 32'(out_result), 32'h00F0);
    check_eq("and_flags", 32'(flags), 32'b001);
    issue(OP_OR, 16'h1200, 16'h0034, 1'b1, 1'b1);
    check_eq("or_result", 32'(out_result), 32'h1234);
    check_eq("or_flags", 32'(flags), 32'b001);
    issue(OP_NOT_A, 16'h00FF, 16'h0000, 1'b1, 1'b1);
    check_eq("not_result", 32'(out_result), 32'hFF00);
    check_eq("not_flags", 32'(flags), 32'b011);
    issue(OP_INC_B, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
    check_eq("inc_wrap", 32'(out_result), 32'h0000);
    check_eq("inc_wrap_flags", 32'(flags), 32'b101);
    issue(OP_INC_B, 16'h0000, 16'h7FFF, 1'b1, 1'b1);
    check_eq("inc_sign", 32'(out_result), 32'h8000);
    check_eq("inc_sign_flags", 32'(flags), 32'b010);
    issue(OP_PASS_B, 16'h0000, 16'h0000, 1'b1, 1'b1);
    check_eq("pass_zero_flags", 32'(flags), 32'b100);

`ifdef EXEC_MUL_EN
    // Iterative multiply: in_ready held low through MUL and DONE
    issue(OP_MUL, 16'h1234, 16'h0100, 1'b1, 1'b1);
    check_eq("mul_busy", 32'(busy), 32'd1);
    stall = 0;
    seen = 0;
    while (in_ready == 1'b0 && stall < 40) begin
      if (out_valid) seen++;
      stall++;
      tick();
    end
    check_eq("mul_stall", 32'(stall), 32'd17);
    check_eq("mul_early_valid", 32'(seen), 32'd0);
    check_eq("mul_valid", 32'(out_valid), 32'd1);
    check_eq("mul_lo", 32'(out_result), 32'h3400);
    check_eq("mul_hi", 32'(out_result_hi), 32'h0012);
    check_eq("mul_flags", 32'(flags), 32'b001);
    check_eq("mul_busy_done", 32'(busy), 32'd0);
`else
    // Without the multiplier op 6 is a single-cycle zero that leaves flags alone
    issue(OP_MUL, 16'h1234, 16'h0100, 1'b1, 1'b1);
    check_eq("op6_valid", 32'(out_valid), 32'd1);
    check_eq("op6_result", 32'(out_result), 32'h0000);
    check_eq("op6_hi", 32'(out_result_hi), 32'h0000);
    check_eq("op6_flags", 32'(flags), 32'b100);
    check_eq("op6_busy", 32'(busy), 32'd0);
`endif

    // Backpressure
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    issue(OP_ADD, 16'h0001, 16'h0002, 1'b0, 1'b1);
    check_eq("bp_result", 32'(out_result), 32'h0003);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    op = OP_PASS_B; imm = 16'h00AA; use_imm = 1'b1; in_valid = 1'b1;
    tick();
    tick();
    check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
    check_eq("bp_hold_result", 32'(out_result), 32'h0003);
    check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("bp_next_result", 32'(out_result), 32'h00AA);
    check_eq("bp_next_valid", 32'(out_valid), 32'd1);

    // Shadow save / restore / swap / restore priority
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 1'b1);
    check_eq("sh_pre_flags", 32'(flags), 32'b101);
    flags_save = 1'b1;
    tick();
    flags_save = 1'b0;
    issue(OP_SUB, 16'h0005, 16'h0005, 1'b1, 1'b1);
    check_eq("sh_sub_flags", 32'(flags), 32'b100);
    flags_restore = 1'b1;
    tick();
    flags_restore = 1'b0;
    check_eq("sh_restore", 32'(flags), 32'b101);
    issue(OP_SUB, 16'h0005, 16'h0005, 1'b1, 1'b1);
    flags_save = 1'b1; flags_restore = 1'b1;
    tick();
    flags_save = 1'b0; flags_restore = 1'b0;
    check_eq("sh_swap", 32'(flags), 32'b101);
    flags_restore = 1'b1;
    issue(OP_ADD, 16'h0001, 16'h0001, 1'b1, 1'b1);
    flags_restore = 1'b0;
    check_eq("sh_prio_result", 32'(out_result), 32'h0002);
    check_eq("sh_prio_flags", 32'(flags), 32'b100);

`ifdef EXEC_MUL_EN
    // Reset during a multiply aborts it
    issue(OP_MUL, 16'h00FF, 16'h0102, 1'b1, 1'b1);
    repeat (4) tick();
    check_eq("rmul_busy", 32'(busy), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("rmul_valid", 32'(out_valid), 32'd0);
    check_eq("rmul_flags", 32'(flags), 32'd0);
    check_eq("rmul_busy_clr", 32'(busy), 32'd0);
    tick();
    Reset = 1'b0;
    tick();
    check_eq("rmul_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check_eq("rmul_no_result", 32'(seen), 32'd0);
`else
    // Asynchronous reset clears held state mid-cycle
    #2;
    Reset = 1'b1;
    #1;
    check_eq("rst2_valid", 32'(out_valid), 32'd0);
    check_eq("rst2_result", 32'(out_result), 32'd0);
    check_eq("rst2_flags", 32'(flags), 32'd0);
    tick();
    Reset = 1'b0;
    tick();
    check_eq("rst2_in_ready", 32'(in_ready), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
